// File: rtl/sync_fifo.sv
// Single-clock FIFO, registered read data (1-cycle latency); writes while full / reads while empty are dropped.
// Define SYNC_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  fifo_full,
    output logic                  fifo_empty
`ifdef SYNC_FIFO_ERR_EN
    ,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]           wr_ptr_q, wr_ptr_d;
    logic [AW:0]           rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic                  wr_acc;
    logic                  rd_acc;

    // Extra wrap bit distinguishes full from empty when the address bits match.
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                        (wr_ptr_q[AW] != rd_ptr_q[AW]);

    assign wr_acc = wr_en && !fifo_full;
    assign rd_acc = rd_en && !fifo_empty;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        rd_data_d = rd_data_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (rd_acc) begin
            rd_ptr_d  = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            rd_data_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Storage is deliberately left out of reset; the cleared pointers make it unreachable.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = rd_data_q;

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    always_comb begin
        overflow_d  = overflow_q  || (wr_en && fifo_full);
        underflow_d = underflow_q || (rd_en && fifo_empty);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_sync_fifo.sv
// Bench for sync_fifo: queue-based reference model checked every cycle plus directed literal checks.
module tb_sync_fifo;

    localparam int DW = 8;
    localparam int DP = 8;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data;
    logic          fifo_full;
    logic          fifo_empty;
`ifdef SYNC_FIFO_ERR_EN
    logic          overflow;
    logic          underflow;
`endif

    sync_fifo #(.DATA_WIDTH(DW), .DEPTH(DP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty)
`ifdef SYNC_FIFO_ERR_EN
        ,
        .overflow   (overflow),
        .underflow  (underflow)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue of words.
    logic [DW-1:0] mq[$];
    logic [DW-1:0] m_rd;
    logic          m_ovf;
    logic          m_unf;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_rd  = '0;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            int sz;
            sz = mq.size();
            if (wr_en && sz == DP) m_ovf = 1'b1;
            if (rd_en && sz == 0)  m_unf = 1'b1;
            if (rd_en && sz > 0)   m_rd = mq.pop_front();
            if (wr_en && sz < DP)  mq.push_back(wr_data);
        end
    end

    always @(negedge clk) begin
        check("rd_data",    32'(rd_data),    32'(m_rd));
        check("fifo_full",  32'(fifo_full),  32'(mq.size() == DP));
        check("fifo_empty", 32'(fifo_empty), 32'(mq.size() == 0));
`ifdef SYNC_FIFO_ERR_EN
        check("overflow",   32'(overflow),   32'(m_ovf));
        check("underflow",  32'(underflow),  32'(m_unf));
`endif
    end

    task automatic step(input logic we, input logic re, input logic [DW-1:0] d);
        @(negedge clk);
        #1;
        wr_en   = we;
        rd_en   = re;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] v;

    initial begin
        rst_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        #2;
        check("reset_empty", 32'(fifo_empty), 32'd1);
        check("reset_full",  32'(fifo_full),  32'd0);
        check("reset_rd",    32'(rd_data),    32'd0);
        release_reset();

        step(1, 0, 8'd5);
        check("first_wr_empty", 32'(fifo_empty), 32'd0);
        check("first_wr_full",  32'(fifo_full),  32'd0);
        step(1, 0, 8'd10);
        step(1, 0, 8'd20);
        step(1, 0, 8'd30);
        check("four_wr_full", 32'(fifo_full), 32'd0);

        step(0, 1, 8'd0);
        check("rd_5", 32'(rd_data), 32'd5);
        step(0, 0, 8'd0);
        check("hold_5", 32'(rd_data), 32'd5);
        step(0, 1, 8'd0);
        check("rd_10", 32'(rd_data), 32'd10);

        step(1, 0, 8'd35);
        step(1, 0, 8'd40);
        step(1, 0, 8'd50);
        step(1, 0, 8'd60);
        step(0, 1, 8'd0);
        check("rd_20", 32'(rd_data), 32'd20);
        step(0, 1, 8'd0);
        check("rd_30", 32'(rd_data), 32'd30);
        step(0, 1, 8'd0);
        check("rd_35_wrap", 32'(rd_data), 32'd35);
        step(0, 1, 8'd0);
        step(0, 1, 8'd0);
        step(0, 1, 8'd0);
        check("rd_60_wrap", 32'(rd_data), 32'd60);
        check("drained_empty", 32'(fifo_empty), 32'd1);

        for (int i = 0; i < 8; i++) step(1, 0, 8'(i));
        check("fill_full", 32'(fifo_full), 32'd1);
        step(1, 0, 8'hFF);
        check("ovf_wr_full", 32'(fifo_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step(0, 1, 8'd0);
            check("fill_order", 32'(rd_data), 32'(i));
        end
        check("fill_drain_empty", 32'(fifo_empty), 32'd1);

        step(0, 1, 8'd0);
        check("unf_rd_hold", 32'(rd_data), 32'd7);
`ifdef SYNC_FIFO_ERR_EN
        check("unf_set",   32'(underflow), 32'd1);
        check("ovf_set",   32'(overflow),  32'd1);
        step(0, 0, 8'd0);
        check("unf_sticky", 32'(underflow), 32'd1);
`endif

        for (int i = 0; i < 8; i++) step(1, 0, 8'hA0 + 8'(i));
        step(1, 1, 8'h55);
        check("full_rw_rd",   32'(rd_data),   32'hA0);
        check("full_rw_full", 32'(fifo_full), 32'd0);
        step(0, 1, 8'd0);
        check("full_rw_next", 32'(rd_data), 32'hA1);

        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_empty", 32'(fifo_empty), 32'd1);
        check("mid_rst_rd",    32'(rd_data),    32'd0);
`ifdef SYNC_FIFO_ERR_EN
        check("mid_rst_unf", 32'(underflow), 32'd0);
        check("mid_rst_ovf", 32'(overflow),  32'd0);
`endif
        wr_en = 1'b0;
        rd_en = 1'b0;
        release_reset();
        step(0, 0, 8'd0);
        check("post_rst_empty", 32'(fifo_empty), 32'd1);

        for (int i = 0; i < 3000; i++) begin
            int mode;
            mode = i / 500;
            v = 8'($urandom);
            case (mode % 3)
                0: step(($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 30), v);
                1: step(($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 70), v);
                default: step(1'($urandom), 1'($urandom), v);
            endcase
            if (i == 1700) begin
                #2;
                rst_n = 1'b0;
                #3;
                wr_en = 1'b0;
                rd_en = 1'b0;
                release_reset();
            end
        end

        wr_en = 1'b0;
        rd_en = 1'b0;
        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 8, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of storage entries; SHALL be a power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 wr_en  input  1  write request; wr_data is captured at the rising clk edge when accepted.
REQ-006 rd_en  input  1  read request; pops the oldest entry when accepted.
REQ-007 wr_data  input  DATA_WIDTH  write data.
REQ-008 rd_data  output  DATA_WIDTH  registered read data.
REQ-009 fifo_full  output  1  high when the FIFO holds DEPTH entries.
REQ-010 fifo_empty  output  1  high when the FIFO holds 0 entries.

Function
REQ-011 Storage SHALL be a DEPTH x DATA_WIDTH array with first-in first-out ordering.
REQ-012 Write and read pointers SHALL be log2(DEPTH)+1 bits wide; the MSB is the wrap bit and the lower bits address the array.
REQ-013 A write SHALL be accepted when wr_en=1 and fifo_full=0: mem[wr_ptr] <= wr_data, and wr_ptr increments.
REQ-014 A read SHALL be accepted when rd_en=1 and fifo_empty=0: rd_data <= mem[rd_ptr], and rd_ptr increments.
REQ-015 Read latency SHALL be one cycle: the data is valid on rd_data after the same edge that accepts rd_en.
REQ-016 rd_data SHALL hold its last value when no read is accepted.
REQ-017 A write while full SHALL be ignored; pointers, memory and flags are unchanged.
REQ-018 A read while empty SHALL be ignored; pointers and rd_data are unchanged.
REQ-019 Simultaneous wr_en and rd_en, neither full nor empty: both SHALL be accepted and the occupancy is unchanged.
REQ-020 Simultaneous wr_en and rd_en while full: only the read SHALL be accepted.
REQ-021 Simultaneous wr_en and rd_en while empty: only the write SHALL be accepted; there is no write-to-read bypass.
REQ-022 fifo_empty SHALL equal (wr_ptr == rd_ptr).
REQ-023 fifo_full SHALL equal (lower bits equal AND wrap bits differ).
REQ-024 Both flags SHALL be derived combinationally from the registered pointers.
REQ-025 Pointers SHALL wrap modulo 2*DEPTH with no loss of ordering.

Reset
REQ-026 When rst_n=0, wr_ptr, rd_ptr and rd_data SHALL clear to 0 immediately, independent of clk.
REQ-027 After reset, fifo_empty SHALL be 1 and fifo_full SHALL be 0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset asserted mid-operation SHALL discard all stored entries.
REQ-030 rst_n SHALL be released synchronously to clk, so that no access occurs on the release edge.

Configuration
REQ-031 Macro SYNC_FIFO_ERR_EN, when defined, SHALL add two outputs, overflow and underflow (each 1 bit).
REQ-032 overflow SHALL be a sticky flag set on any write attempted while full.
REQ-033 underflow SHALL be a sticky flag set on any read attempted while empty.
REQ-034 overflow and underflow SHALL be cleared only by reset.
REQ-035 Without SYNC_FIFO_ERR_EN, these outputs and their logic SHALL be absent; all other behaviour is identical in both builds.

Verification
REQ-036 Reset, then write 5, 10, 20, 30 on consecutive cycles -> fifo_empty=0 after the first write, fifo_full=0 throughout.
REQ-037 Continue with read, idle, read -> rd_data=5, then holds 5 during the idle cycle, then rd_data=10.
REQ-038 Continue with write 35, 40, 50, 60, then read twice -> rd_data=20, then 30; order is preserved across pointer wrap.
REQ-039 From empty, write 0..7 -> fifo_full=1; a 9th write of 8'hFF is ignored; 8 reads return 0..7 in order, then fifo_empty=1.
REQ-040 Read while empty -> rd_data unchanged; with SYNC_FIFO_ERR_EN, underflow=1 and stays 1 until rst_n is pulsed.
REQ-041 Full FIFO with wr_en=rd_en=1 -> the oldest entry is read, the write is dropped, and fifo_full deasserts. Then assert rst_n low mid-stream -> fifo_empty=1 and rd_data=0 immediately.
